// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one synchronous single-port RAM between the VGA
// scan-out reader (absolute priority) and the interpolation engine.
// Read data returns two cycles after the winning request is sampled and
// is routed back to its owner through a short tag pipeline.
//
// Processor handshake: proc_req is a request-valid held with proc_we,
// proc_addr and proc_wdata stable until proc_gnt is seen; proc_gnt acts as
// a one-cycle ready that consumes exactly one request at the next edge, so
// holding proc_req high across consecutive grants issues consecutive accesses.
// VGA has no ready: every cycle with vga_req high is issued unconditionally.
module vram_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 800
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    output logic          vga_valid,
    input  logic          proc_req,
    input  logic          proc_we,
    input  logic [AW-1:0] proc_addr,
    input  logic [DW-1:0] proc_wdata,
    output logic          proc_gnt,
    output logic [DW-1:0] proc_rdata,
    output logic          proc_rvalid,
    output logic          proc_starved,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VGA_RD  = 2'd1,
        PROC_RD = 2'd2,
        PROC_WR = 2'd3
    } state_t;

    // state_q is the first tag stage (the access on the RAM bus now);
    // tag_q is the second stage (the access whose data is on mem_rdata now).
    state_t        state_q, state_d;
    state_t        tag_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] vga_data_q;
    logic          vga_valid_q;
    logic [DW-1:0] proc_rdata_q;
    logic          proc_rvalid_q;
    logic [11:0]   wait_cnt_q, wait_cnt_d;
    logic          starved_q;

    // Priority decode of the next access and the processor grant/wait counter.
    always_comb begin
        state_d = IDLE;
        if (vga_req) begin
            state_d = VGA_RD;
        end else if (proc_req) begin
            state_d = proc_we ? PROC_WR : PROC_RD;
        end

        proc_gnt = reset & ~vga_req & proc_req;

        wait_cnt_d = 12'd0;
        if (proc_req && !proc_gnt) begin
            wait_cnt_d = (wait_cnt_q == 12'hFFF) ? wait_cnt_q : wait_cnt_q + 12'd1;
        end
    end

    // Issue FSM, registered RAM port, tag pipeline, read return and starvation flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            tag_q         <= IDLE;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            vga_data_q    <= '0;
            vga_valid_q   <= 1'b0;
            proc_rdata_q  <= '0;
            proc_rvalid_q <= 1'b0;
            wait_cnt_q    <= 12'd0;
            starved_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_d)
                VGA_RD: begin
                    mem_addr_q <= vga_addr;
                    mem_we_q   <= 1'b0;
                end
                PROC_RD: begin
                    mem_addr_q <= proc_addr;
                    mem_we_q   <= 1'b0;
                end
                PROC_WR: begin
                    mem_addr_q  <= proc_addr;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= proc_wdata;
                end
                default: begin
                    // Address is left alone so the RAM sees a stable bus when idle.
                    mem_we_q <= 1'b0;
                end
            endcase

            tag_q <= state_q;

            vga_valid_q   <= (tag_q == VGA_RD);
            proc_rvalid_q <= (tag_q == PROC_RD);
            if (tag_q == VGA_RD) begin
                vga_data_q <= mem_rdata;
            end
            if (tag_q == PROC_RD) begin
                proc_rdata_q <= mem_rdata;
            end

            wait_cnt_q <= wait_cnt_d;
            starved_q  <= (32'(wait_cnt_d) >= STARVE_LIMIT);
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign vga_data     = vga_data_q;
    assign vga_valid    = vga_valid_q;
    assign proc_rdata   = proc_rdata_q;
    assign proc_rvalid  = proc_rvalid_q;
    assign proc_starved = starved_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous single-port RAM model.
module tb_vram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic          proc_req;
    logic          proc_we;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_wdata;
    logic          proc_gnt;
    logic [DW-1:0] proc_rdata;
    logic          proc_rvalid;
    logic          proc_starved;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    dbg_state;

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(800)) dut (
        .clk          (clk),
        .reset        (reset),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data),
        .vga_valid    (vga_valid),
        .proc_req     (proc_req),
        .proc_we      (proc_we),
        .proc_addr    (proc_addr),
        .proc_wdata   (proc_wdata),
        .proc_gnt     (proc_gnt),
        .proc_rdata   (proc_rdata),
        .proc_rvalid  (proc_rvalid),
        .proc_starved (proc_starved),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state)
    );

    // ---------------- RAM model ----------------
    logic [DW-1:0] ram [0:(1<<AW)-1];

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock edge; returns at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_vga(input logic req, input logic [AW-1:0] a);
        vga_req  = req;
        vga_addr = a;
    endtask

    task automatic set_proc(input logic req, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        proc_req   = req;
        proc_we    = we;
        proc_addr  = a;
        proc_wdata = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = pix(16'(i));
        mem_rdata = '0;

        // Reset held 2 cycles with both requesters active.
        reset = 1'b0;
        set_vga(1'b1, 16'h0005);
        set_proc(1'b1, 1'b0, 16'h0007, 8'h00);
        @(negedge clk);
        check("gnt_in_reset", proc_gnt, 0);
        cyc();
        cyc();
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_vga_data", vga_data, 0);
        check("rst_vga_valid", vga_valid, 0);
        check("rst_proc_rdata", proc_rdata, 0);
        check("rst_proc_rvalid", proc_rvalid, 0);
        check("rst_starved", proc_starved, 0);
        check("rst_state", dbg_state, 0);
        check("rst_gnt", proc_gnt, 0);

        // Release: first valid exactly two edges after the first issue edge.
        reset = 1'b1;
        #1 check("rel_gnt_vga_wins", proc_gnt, 0);
        cyc();
        check("rel_e0_valid", vga_valid, 0);
        check("rel_e0_addr", mem_addr, 16'h0005);
        check("rel_e0_state", dbg_state, 1);
        cyc();
        check("rel_e1_valid", vga_valid, 0);
        cyc();
        check("rel_e2_valid", vga_valid, 1);
        check("rel_e2_data", vga_data, pix(16'h0005));
        check("rel_e2_prvalid", proc_rvalid, 0);
        set_vga(1'b0, 16'h0000);
        set_proc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc();
        cyc();
        cyc();
        check("drain_vga_valid", vga_valid, 0);
        check("drain_starved", proc_starved, 0);

        // 800-cycle VGA burst with a processor read pending throughout.
        for (int i = 0; i < 800; i++) begin
            set_vga(1'b1, 16'(i));
            set_proc(1'b1, 1'b0, 16'h0020, 8'h00);
            exp_q.push_back(pix(16'(i)));
            #1 check("burst_gnt", proc_gnt, 0);
            cyc();
            check("burst_we", mem_we, 0);
            check("burst_starved", proc_starved, (i + 1 >= 800) ? 1 : 0);
            if (i >= 2) begin
                check("burst_valid", vga_valid, 1);
                check("burst_data", vga_data, exp_q.pop_front());
            end else begin
                check("burst_fill_valid", vga_valid, 0);
            end
            check("burst_prvalid", proc_rvalid, 0);
        end
        set_vga(1'b0, 16'h0000);
        #1 check("burst_end_gnt", proc_gnt, 1);
        cyc();
        check("burst_tail0_valid", vga_valid, 1);
        check("burst_tail0_data", vga_data, exp_q.pop_front());
        check("burst_starved_clr", proc_starved, 0);
        set_proc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc();
        check("burst_tail1_valid", vga_valid, 1);
        check("burst_tail1_data", vga_data, exp_q.pop_front());
        check("burst_tail1_prvalid", proc_rvalid, 0);
        cyc();
        check("burst_proc_rvalid", proc_rvalid, 1);
        check("burst_proc_rdata", proc_rdata, pix(16'h0020));
        check("burst_tail2_valid", vga_valid, 0);
        cyc();

        // Processor write then read-back of the same address, back-to-back grants.
        set_proc(1'b1, 1'b1, 16'h0010, 8'hA5);
        #1 check("wr_gnt", proc_gnt, 1);
        cyc();
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 16'h0010);
        check("wr_mem_wdata", mem_wdata, 8'hA5);
        check("wr_state", dbg_state, 3);
        set_proc(1'b1, 1'b0, 16'h0010, 8'h00);
        #1 check("rd_gnt", proc_gnt, 1);
        cyc();
        check("rd_mem_we", mem_we, 0);
        check("rd_mem_addr", mem_addr, 16'h0010);
        set_proc(1'b0, 1'b0, 16'h0000, 8'h00);
        #1 check("idle_gnt", proc_gnt, 0);
        cyc();
        check("wr_slot_prvalid", proc_rvalid, 0);
        check("wr_slot_vvalid", vga_valid, 0);
        check("idle_mem_addr_hold", mem_addr, 16'h0010);
        check("idle_mem_we", mem_we, 0);
        cyc();
        check("rd_prvalid", proc_rvalid, 1);
        check("rd_prdata", proc_rdata, 8'hA5);
        check("rd_vvalid", vga_valid, 0);
        cyc();
        check("rd_after_prvalid", proc_rvalid, 0);
        check("rd_hold_prdata", proc_rdata, 8'hA5);

        // Alternating vga_req with processor reads pending.
        set_vga(1'b1, 16'h0040);
        set_proc(1'b1, 1'b0, 16'h0030, 8'h00);
        #1 check("alt0_gnt", proc_gnt, 0);
        cyc();
        set_vga(1'b0, 16'h0000);
        #1 check("alt1_gnt", proc_gnt, 1);
        cyc();
        check("alt1_vvalid", vga_valid, 0);
        check("alt1_prvalid", proc_rvalid, 0);
        set_vga(1'b1, 16'h0041);
        set_proc(1'b1, 1'b0, 16'h0031, 8'h00);
        #1 check("alt2_gnt", proc_gnt, 0);
        cyc();
        check("alt2_vvalid", vga_valid, 1);
        check("alt2_vdata", vga_data, pix(16'h0040));
        check("alt2_prvalid", proc_rvalid, 0);
        set_vga(1'b0, 16'h0000);
        #1 check("alt3_gnt", proc_gnt, 1);
        cyc();
        check("alt3_vvalid", vga_valid, 0);
        check("alt3_prvalid", proc_rvalid, 1);
        check("alt3_prdata", proc_rdata, pix(16'h0030));
        set_proc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc();
        check("alt4_vvalid", vga_valid, 1);
        check("alt4_vdata", vga_data, pix(16'h0041));
        check("alt4_prvalid", proc_rvalid, 0);
        cyc();
        check("alt5_vvalid", vga_valid, 0);
        check("alt5_prvalid", proc_rvalid, 1);
        check("alt5_prdata", proc_rdata, pix(16'h0031));
        cyc();

        // Reset the cycle after a VGA read issue: that read never returns.
        set_vga(1'b1, 16'h0050);
        cyc();
        check("abort_issue_addr", mem_addr, 16'h0050);
        set_vga(1'b0, 16'h0000);
        reset = 1'b0;
        cyc();
        check("abort_rst_valid", vga_valid, 0);
        check("abort_rst_addr", mem_addr, 0);
        reset = 1'b1;
        cyc();
        check("abort_p1_valid", vga_valid, 0);
        cyc();
        check("abort_p2_valid", vga_valid, 0);
        check("abort_p2_data", vga_data, 0);

        // Simultaneous VGA read and processor write: write lands next free cycle.
        set_vga(1'b1, 16'h0060);
        set_proc(1'b1, 1'b1, 16'h0061, 8'h5A);
        #1 check("sim_gnt0", proc_gnt, 0);
        cyc();
        check("sim_e0_we", mem_we, 0);
        check("sim_e0_addr", mem_addr, 16'h0060);
        set_vga(1'b0, 16'h0000);
        #1 check("sim_gnt1", proc_gnt, 1);
        cyc();
        check("sim_e1_we", mem_we, 1);
        check("sim_e1_addr", mem_addr, 16'h0061);
        check("sim_e1_wdata", mem_wdata, 8'h5A);
        set_proc(1'b1, 1'b0, 16'h0061, 8'h00);
        #1 check("sim_rb_gnt", proc_gnt, 1);
        cyc();
        check("sim_e2_vvalid", vga_valid, 1);
        check("sim_e2_vdata", vga_data, pix(16'h0060));
        check("sim_e2_we", mem_we, 0);
        set_proc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc();
        check("sim_e3_vvalid", vga_valid, 0);
        check("sim_e3_prvalid", proc_rvalid, 0);
        cyc();
        check("sim_rb_prvalid", proc_rvalid, 1);
        check("sim_rb_prdata", proc_rdata, 8'h5A);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
